// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus: redirect input, code-memory request/response port and
// the IR/NPC stream toward the IF/ID register.
interface mips32_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_npc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_ready,
        output imem_req_valid, imem_addr,
        output out_valid, out_ir, out_npc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_ready,
        input  imem_req_valid, imem_addr,
        input  out_valid, out_ir, out_npc
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited code
// reads, buffers responses in a show-ahead FIFO and squashes wrong-path data.
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    mips32_fetch_queue_if.master fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   ir_mem  [DEPTH];
    logic [31:0]   npc_mem [DEPTH];

    logic [31:0]   used_credit;
    logic          credit_ok, outst_ok;
    logic          req_fire, push, pop;

    // Only live (non-dropped) requests consume FIFO credit.
    assign used_credit = 32'(count_q) + 32'(outst_q) - 32'(drop_q);
    assign credit_ok   = used_credit < 32'(DEPTH);
    assign outst_ok    = 32'(outst_q) < 32'(MAX_OUT);

    assign fq.imem_req_valid = !rst && !fq.redirect_valid && outst_ok && credit_ok;
    assign fq.imem_addr      = fetch_pc_q;
    assign fq.out_valid      = (count_q != '0) && !fq.redirect_valid;
    assign fq.out_ir         = (count_q != '0) ? ir_mem[rd_ptr_q]  : 32'h0;
    assign fq.out_npc        = (count_q != '0) ? npc_mem[rd_ptr_q] : 32'h0;

    assign req_fire = fq.imem_req_valid && fq.imem_req_ready;
    assign pop      = fq.out_valid && fq.out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push       = 1'b0;

        if (fq.redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d = fq.redirect_pc;
            rsp_pc_d   = fq.redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            outst_d    = outst_q - OW'(fq.imem_rsp_valid);
            drop_d     = outst_q - OW'(fq.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            outst_d = outst_q + OW'(req_fire) - OW'(fq.imem_rsp_valid);
            if (fq.imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is data only; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= fq.imem_rsp_data;
            npc_mem[wr_ptr_q] <= rsp_pc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fq.imem_rsp_valid && (outst_q == '0)));
            assert (drop_q <= outst_q);
        end
    end
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed and random bench for mips32_fetch_queue with a variable-latency
// code-memory model and an architectural-path scoreboard.
module tb_mips32_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips32_fetch_queue_if bus();

    mips32_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ir[$];
    logic [31:0] exp_npc[$];
    logic [31:0] mq_data[$];
    int          mq_due[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_pop = 0;
    int          n_acc = 0;
    int          first_req_cyc = -1;
    int          first_out_cyc = -1;
    logic [31:0] last_ir = '0;
    logic [31:0] last_npc = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[27:0], a[31:28]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic phase_a();
        if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mq_data.pop_front();
            void'(mq_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic phase_b();
        int due;
        if (!rst) begin
            if (bus.redirect_valid) begin
                check("redir_out_valid", 32'(bus.out_valid), 32'd0);
                check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
                exp_ir.delete();
                exp_npc.delete();
            end else begin
                if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    check("sb_has_entry", (exp_ir.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_ir.size() != 0) begin
                        check("out_ir", bus.out_ir, exp_ir.pop_front());
                        check("out_npc", bus.out_npc, exp_npc.pop_front());
                    end
                    last_ir  = bus.out_ir;
                    last_npc = bus.out_npc;
                    n_pop++;
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                exp_ir.push_back(memf(bus.imem_addr));
                exp_npc.push_back(bus.imem_addr + 32'd1);
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_data.push_back(memf(bus.imem_addr));
                mq_due.push_back(due);
                n_acc++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick();
        phase_a();
        phase_b();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        // Hold reset until every old response has come back.
        for (int i = 0; i < 40 && (i < 2 || mq_due.size() != 0); i++) tick();
        exp_ir.delete();
        exp_npc.delete();
        first_req_cyc = -1;
        first_out_cyc = -1;
        last_due = cyc;
        rst = 1'b0;
    endtask

    task automatic settle();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b1;
        repeat (14) tick();
        check("drained", exp_ir.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, a0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.out_ready      = 1'b0;
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        phase_a();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_out_ir", bus.out_ir, 32'h0);
        check("rst_out_npc", bus.out_npc, 32'h0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        phase_b();

        // Streaming, latency 1
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        phase_a();
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_addr, RESET_PC);
        phase_b();
        for (int i = 0; i < 10 && first_out_cyc < 0; i++) tick();
        check("first_out_latency", 32'(first_out_cyc - first_req_cyc), 32'd2);
        p0 = n_pop;
        repeat (20) tick();
        check("sustained_rate", 32'(n_pop - p0), 32'd20);
        settle();

        // ID stall fills the FIFO
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        a0 = n_acc;
        repeat (10) begin
            phase_a();
            if (bus.out_valid) begin
                check("stall_ir_held", bus.out_ir, 32'h0);
                check("stall_npc_held", bus.out_npc, 32'h1);
            end
            phase_b();
        end
        check("stall_accepts", 32'(n_acc - a0), 32'(DEPTH));
        phase_a();
        check("stall_req_low", 32'(bus.imem_req_valid), 32'd0);
        phase_b();
        bus.out_ready = 1'b1;
        p0 = n_pop;
        repeat (20) tick();
        check("release_pops", 32'(n_pop - p0), 32'd20);
        settle();

        // Redirect with two old requests in flight, latency 3
        do_reset();
        lat_min = 3; lat_max = 3;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        phase_a();
        check("redir_req_valid_next", 32'(bus.imem_req_valid), 32'd1);
        check("redir_addr_next", bus.imem_addr, 32'h40);
        phase_b();
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) tick();
        check("redir_first_ir", last_ir, memf(32'h40));
        check("redir_first_npc", last_npc, 32'h41);
        settle();

        // Redirect coinciding with a response and a pop
        do_reset();
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (6) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        phase_a();
        check("coinc_rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
        phase_b();
        bus.redirect_valid = 1'b0;
        phase_a();
        check("coinc_fifo_empty", 32'(bus.out_valid), 32'd0);
        check("coinc_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("coinc_addr", bus.imem_addr, 32'h100);
        phase_b();
        repeat (10) tick();

        // Fetch PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (10) tick();
        settle();

        // Random traffic with redirects
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            bus.imem_req_ready = ($urandom % 2) == 0;
            bus.out_ready      = ($urandom % 4) != 0;
            bus.redirect_valid = ($urandom % 20) == 0;
            bus.redirect_pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFFC + ($urandom % 4))
                                                       : ($urandom % 256);
            tick();
        end
        settle();

        // Reset while the FIFO holds data and requests are outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        phase_a();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("midrst_addr", bus.imem_addr, RESET_PC);
        check("midrst_out_ir", bus.out_ir, 32'h0);
        phase_b();
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        phase_a();
        check("postrst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("postrst_addr", bus.imem_addr, RESET_PC);
        check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        phase_b();
        repeat (12) tick();
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
